// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared types and helpers for the capture sequencer
package la_pkg;

  localparam int PRESCALE_W = 29;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    RISING  = 2'b01,
    FALLING = 2'b10,
    BOTH    = 2'b11
  } trig_kind_e;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    WAIT_TRIG,
    POSTTRIG,
    DONE
  } cap_state_e;

  function automatic logic edge_fire(input logic [1:0] kind, input logic prev, input logic cur);
    case (kind)
      RISING:  edge_fire = ~prev & cur;
      FALLING: edge_fire = prev & ~cur;
      BOTH:    edge_fire = prev ^ cur;
      default: edge_fire = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - prescaler producing one tick every factor cycles (0 acts as 1)
module sample_tick_gen #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] factor,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic [W-1:0] limit;

  always_comb begin
    limit = '0;
    if (factor != '0) limit = factor - 1'b1;
  end

  assign tick = enable && (cnt == limit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - one logic-analyser acquisition: strobe, capture, trigger, pre-trigger window
module capture_sequencer #(
  parameter int NUM_CH     = 16,
  parameter int ADDR_W     = 10,
  parameter int PRE_TRIG   = 256,
  parameter int PRESCALE_W = la_pkg::PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [PRESCALE_W-1:0] prescaling_factor,
  input  logic [2*NUM_CH-1:0]   trigger_kind,
  input  logic [NUM_CH-1:0]     probe_in,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [NUM_CH-1:0]     mem_wdata,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic [ADDR_W-1:0]     trig_addr,
  output logic [ADDR_W-1:0]     start_addr
);
  import la_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_CNT   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 2);
  localparam bit                NO_POST   = (DEPTH - PRE_TRIG == 1);

  cap_state_e state, state_nxt;

  logic [PRESCALE_W-1:0] fac_q;
  logic [2*NUM_CH-1:0]   kind_q;
  logic                  accept, tick, capturing, trig_found;
  logic [ADDR_W-1:0]     s_cnt, post_cnt, wr_ptr;
  logic [NUM_CH-1:0]     prev_sample, pend_data;
  logic                  pend_we, pend_pre_last, pend_trig, pend_last;
  logic                  fire, is_trig, is_last;

  assign accept = arm && !abort && (state == IDLE || state == DONE);

  sample_tick_gen #(.W(PRESCALE_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (capturing),
    .factor (fac_q),
    .tick   (tick)
  );

  // Decisions are taken per captured sample, not per FSM state, so F=1 overlap of
  // one sample's write with the next sample's capture stays correct.
  always_comb begin
    fire = (kind_q == '0);
    for (int c = 0; c < NUM_CH; c++) begin
      fire = fire | edge_fire(kind_q[2*c +: 2], prev_sample[c], probe_in[c]);
    end
    is_trig = (s_cnt == PRE_CNT) && !trig_found && fire;
    is_last = (is_trig && NO_POST) || (trig_found && post_cnt == POST_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fac_q         <= '0;
      kind_q        <= '0;
      capturing     <= 1'b0;
      trig_found    <= 1'b0;
      s_cnt         <= '0;
      post_cnt      <= '0;
      prev_sample   <= '0;
      pend_data     <= '0;
      pend_we       <= 1'b0;
      pend_pre_last <= 1'b0;
      pend_trig     <= 1'b0;
      pend_last     <= 1'b0;
    end else if (abort) begin
      capturing <= 1'b0;
      pend_we   <= 1'b0;
    end else if (accept) begin
      fac_q      <= prescaling_factor;
      kind_q     <= trigger_kind;
      capturing  <= 1'b1;
      trig_found <= 1'b0;
      s_cnt      <= '0;
      post_cnt   <= '0;
      pend_we    <= 1'b0;
    end else begin
      pend_we <= tick;
      if (tick) begin
        pend_data     <= probe_in;
        prev_sample   <= probe_in;
        pend_pre_last <= (s_cnt == PRE_LAST);
        pend_trig     <= is_trig;
        pend_last     <= is_last;
        if (s_cnt != PRE_CNT) s_cnt <= s_cnt + 1'b1;
        if (is_trig) trig_found <= 1'b1;
        if (trig_found) post_cnt <= post_cnt + 1'b1;
        if (is_last) capturing <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else if (accept) begin
      wr_ptr <= '0;
    end else if (pend_we) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (pend_trig) begin
        trig_addr  <= wr_ptr;
        start_addr <= wr_ptr - PRE_CNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (arm) state_nxt = PRETRIG;
        PRETRIG:    if (pend_we && pend_pre_last) state_nxt = WAIT_TRIG;
        WAIT_TRIG:  if (pend_we && pend_trig) state_nxt = pend_last ? DONE : POSTTRIG;
        POSTTRIG:   if (pend_we && pend_last) state_nxt = DONE;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  assign mem_we    = pend_we;
  assign mem_addr  = wr_ptr;
  assign mem_wdata = pend_data;
  assign busy      = (state == PRETRIG) || (state == WAIT_TRIG) || (state == POSTTRIG);
  assign triggered = (state == POSTTRIG) || (state == DONE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - randomized self-checking bench against a sample-level acquisition model
module tb_capture_sequencer;

  localparam int NUM_CH = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int PRE    = 4;
  localparam int PW     = 29;
  localparam int NSMP   = 256;

  logic              clk = 1'b0;
  logic              rst, arm, abort;
  logic [PW-1:0]     prescaling_factor;
  logic [2*NUM_CH-1:0] trigger_kind;
  logic [NUM_CH-1:0] probe_in;
  logic              mem_we, busy, triggered, done;
  logic [ADDR_W-1:0] mem_addr, trig_addr, start_addr;
  logic [NUM_CH-1:0] mem_wdata;

  capture_sequencer #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .PRE_TRIG(PRE), .PRESCALE_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort),
    .prescaling_factor(prescaling_factor), .trigger_kind(trigger_kind), .probe_in(probe_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .triggered(triggered), .done(done),
    .trig_addr(trig_addr), .start_addr(start_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [NUM_CH-1:0] smp [0:NSMP-1];
  int trig_idx;
  int total;

  function automatic bit ch_fires(input logic [1:0] k, input logic p, input logic c);
    if (k == 2'b01) return !p && c;
    if (k == 2'b10) return p && !c;
    if (k == 2'b11) return p != c;
    return 1'b0;
  endfunction

  // Acquisition outcome from the sample list: trigger index and number of samples written.
  task automatic plan(input logic [2*NUM_CH-1:0] kinds);
    trig_idx = -1;
    if (kinds == '0) trig_idx = PRE;
    else begin
      for (int j = PRE; j < NSMP && trig_idx < 0; j++)
        for (int c = 0; c < NUM_CH; c++)
          if (ch_fires(kinds[2*c +: 2], smp[j-1][c], smp[j][c])) trig_idx = j;
    end
    total = (trig_idx < 0) ? 1000000 : trig_idx + DEPTH - PRE;
  endtask

  task automatic acquire(input string tag, input int pf, input logic [31:0] kinds, input int ncyc_in,
                         input int abort_rel, input int stray_rel, input int pf_rel, input int rst_rel);
    int f, k, last_rel, ncyc;
    bit ew, eb, et, ed, stopped;
    f = (pf == 0) ? 1 : pf;
    plan(kinds);
    last_rel = total * f + 1;
    ncyc = ncyc_in;
    if (ncyc == 0) ncyc = (trig_idx < 0) ? 100 : last_rel + 3;
    @(negedge clk);
    arm = 1'b1;
    prescaling_factor = PW'(pf);
    trigger_kind = kinds;
    probe_in = NUM_CH'($urandom);
    stopped = 1'b0;
    for (int rel = 1; rel <= ncyc && !stopped; rel++) begin
      @(negedge clk);
      arm = 1'b0; abort = 1'b0; rst = 1'b0;
      ew = 1'b0; k = 0;
      if (rel >= f + 1 && (rel - 1) % f == 0) begin
        k = (rel - 1) / f;
        ew = (k <= total);
      end
      eb = (rel <= last_rel);
      ed = !eb;
      et = (trig_idx >= 0) && (rel > (trig_idx + 1) * f + 1);
      n_cmp++;
      if (mem_we !== ew) begin
        n_bad++;
        $display("FAIL %s we rel=%0d: got %b want %b", tag, rel, mem_we, ew);
      end
      if (ew) begin
        n_cmp++;
        if (mem_addr !== ADDR_W'((k - 1) % DEPTH) || mem_wdata !== smp[k-1]) begin
          n_bad++;
          $display("FAIL %s wr rel=%0d: got addr %0d data %h want addr %0d data %h",
                   tag, rel, mem_addr, mem_wdata, (k - 1) % DEPTH, smp[k-1]);
        end
      end
      n_cmp++;
      if ({busy, triggered, done} !== {eb, et, ed}) begin
        n_bad++;
        $display("FAIL %s flags rel=%0d: got busy/trig/done %b%b%b want %b%b%b",
                 tag, rel, busy, triggered, done, eb, et, ed);
      end
      if (rel == last_rel + 1) begin
        n_cmp++;
        if (trig_addr !== ADDR_W'(trig_idx % DEPTH) ||
            start_addr !== ADDR_W'((trig_idx - PRE + DEPTH) % DEPTH)) begin
          n_bad++;
          $display("FAIL %s addrs: got trig %0d start %0d want trig %0d start %0d", tag,
                   trig_addr, start_addr, trig_idx % DEPTH, (trig_idx - PRE + DEPTH) % DEPTH);
        end
      end
      trigger_kind = {$urandom, $urandom};
      if (pf_rel > 0 && rel >= pf_rel) prescaling_factor = PW'(8);
      if (rel % f == 0 && rel / f - 1 < NSMP) probe_in = smp[rel/f - 1];
      else probe_in = NUM_CH'($urandom);
      if (rel == stray_rel) arm = 1'b1;
      if (rel == abort_rel) begin abort = 1'b1; arm = 1'b1; end
      if (rel == rst_rel) rst = 1'b1;
      if (rel == abort_rel || rel == rst_rel) begin
        @(negedge clk);
        arm = 1'b0; abort = 1'b0; rst = 1'b0;
        n_cmp++;
        if ({mem_we, busy, triggered, done} !== 4'b0000) begin
          n_bad++;
          $display("FAIL %s stop_flags: got we/busy/trig/done %b%b%b%b want 0000",
                   tag, mem_we, busy, triggered, done);
        end
        if (rel == rst_rel) begin
          n_cmp++;
          if ({mem_addr, mem_wdata, trig_addr, start_addr} !== '0) begin
            n_bad++;
            $display("FAIL %s rst_outputs: got addr %0d data %h trig %0d start %0d want all 0",
                     tag, mem_addr, mem_wdata, trig_addr, start_addr);
          end
        end else begin
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_we, busy, done} !== 3'b000) begin
              n_bad++;
              $display("FAIL %s idle_hold: got we/busy/done %b%b%b want 000", tag, mem_we, busy, done);
            end
          end
        end
        stopped = 1'b1;
      end
    end
    if (!stopped && ncyc <= last_rel) begin
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NSMP; i++) smp[i] = NUM_CH'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b1; abort = 1'b0;
    prescaling_factor = PW'(1); trigger_kind = '0; probe_in = NUM_CH'($urandom);
    repeat (3) @(negedge clk);
    rst = 1'b0; arm = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_we, busy, triggered, done} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got we/busy/trig/done %b%b%b%b want 0000", mem_we, busy, triggered, done);
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, trig_addr, start_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_buses: got addr %0d data %h trig %0d start %0d want all 0",
               mem_addr, mem_wdata, trig_addr, start_addr);
    end
  endtask

  task automatic test_f1_rising();
    fill_random();
    for (int i = 0; i < NSMP; i++) smp[i][0] = (i >= 10);
    acquire("f1_rising", 1, 32'h0000_0001, 0, -1, 2, -1, -1);
  endtask

  task automatic test_f4_free_run();
    fill_random();
    acquire("f4_free_run", 4, 32'h0, 0, -1, 7, -1, -1);
  endtask

  task automatic test_no_trigger_then_rst();
    fill_random();
    for (int i = 0; i < NSMP; i++) smp[i][3] = (i < 2);
    acquire("no_trig_rst", 1, 32'h0000_0080, 40, -1, -1, -1, 25);
  endtask

  task automatic test_abort();
    fill_random();
    acquire("abort_post", 2, 32'h0, 40, 18, -1, -1, -1);
  endtask

  task automatic test_config_latch();
    fill_random();
    acquire("pf_change", 1, 32'h0, 0, -1, -1, 3, -1);
    fill_random();
    acquire("rearm_f8", 8, 32'h0000_0c00, 0, -1, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      smp[0] = NUM_CH'($urandom);
      for (int i = 1; i < NSMP; i++) begin
        smp[i] = smp[i-1];
        if ($urandom_range(0, 3) == 0) smp[i][$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      end
      acquire("random", int'($urandom_range(0, 3)), $urandom & $urandom, 0, -1, -1, -1, -1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_f1_rising();
    test_f4_free_run();
    test_no_trigger_then_rst();
    test_abort();
    test_config_latch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences one logic-analyser acquisition: generates the sample strobe from the prescaling factor, captures the probe bus into the sample RAM, evaluates per-channel edge triggers, and retains a fixed pre-trigger window.
- Consumes the timebase/trigger configuration produced by the front-panel controller; drives the write port of the external sample RAM; reports trigger/start addresses to the readout logic.

Parameters:
- NUM_CH, 16, probe channels
- ADDR_W, 10, sample RAM address width; DEPTH = 2**ADDR_W
- PRE_TRIG, 256, samples kept before trigger sample; legal range 1..DEPTH-1
- PRESCALE_W, 29, prescaling factor width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- arm  in  1  single-cycle pulse, start acquisition
- abort  in  1  single-cycle pulse, cancel acquisition
- prescaling_factor  in  PRESCALE_W  clk cycles per sample; 0 treated as 1
- trigger_kind  in  2 x NUM_CH  per channel: 00 none, 01 rising, 10 falling, 11 both
- probe_in  in  NUM_CH  probe bus, already synchronised to clk
- mem_we  out  1  RAM write strobe
- mem_addr  out  ADDR_W  RAM write address
- mem_wdata  out  NUM_CH  RAM write data
- busy  out  1  acquisition in progress
- triggered  out  1  trigger seen in current acquisition
- done  out  1  buffer complete; held until next arm/abort/rst
- trig_addr  out  ADDR_W  address of trigger sample
- start_addr  out  ADDR_W  address of oldest valid sample = trig_addr - PRE_TRIG mod DEPTH

Behaviour:
- One clock; reset is synchronous and active-high. rst: state IDLE, all outputs 0, wr_ptr 0, tick counter 0.
- Config latch: prescaling_factor and trigger_kind are latched on arm acceptance; later changes have no effect until the next arm.
- Tick gen: counter cleared on arm acceptance and counts 0..F-1 (F = latched factor, min 1). Tick when counter == F-1, then wrap to 0. F=1: tick every cycle from the cycle after arm. F=N: first tick N cycles after arm.
- Write path:
  - On a tick cycle, probe_in is captured.
  - Next cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=captured sample; wr_ptr increments mod DEPTH.
  - Latency: 1 cycle tick-to-write. mem_we is never high for two consecutive cycles unless F=1.
- Edge detect: prev_sample holds the previous captured sample. Channel c fires if kind 01 and 0->1, kind 10 and 1->0, or kind 11 and any change. Trigger = OR over channels.
- States:
  - IDLE: arm -> PRETRIG (wr_ptr=0, counters cleared, busy=1, triggered=0, done=0).
  - PRETRIG: writes PRE_TRIG samples, no trigger evaluation. After the PRE_TRIG-th write -> WAIT_TRIG.
  - WAIT_TRIG: circular writes. Each sample is evaluated against prev_sample before being written.
    - Firing sample: written normally, trig_addr = its address, triggered=1 -> POSTTRIG.
    - All kinds 00: first WAIT_TRIG sample triggers unconditionally (free run).
  - POSTTRIG: writes exactly DEPTH-PRE_TRIG-1 further samples. After the last write -> DONE next cycle (busy=0, done=1, start_addr valid).
  - DONE: holds outputs. arm -> PRETRIG as from IDLE.
- Arm handling: arm in PRETRIG/WAIT_TRIG/POSTTRIG is ignored.
- Abort: in any state -> IDLE next cycle. mem_we=0 from that cycle, busy=0, done=0, triggered=0. Abort has priority over a simultaneous arm. A pending write from the abort cycle's tick is dropped.
- rst mid-acquisition: same effect as abort, plus all outputs cleared.
- Wrap-around: wr_ptr wraps DEPTH-1 -> 0 silently in WAIT_TRIG, which may run indefinitely.

Decomposition:
- Shared package la_pkg:
  - trig_kind_e enum (NONE=00, RISING=01, FALLING=10, BOTH=11)
  - cap_state_e enum (IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE)
  - PRESCALE_W constant
- Sub-module sample_tick_gen: prescaler counter with clear input, tick output.

Test Plan:
- All scenarios use ADDR_W=4 (DEPTH=16), PRE_TRIG=4.
- F=1, ch0 RISING, ch0 0->1 at sample index 10 -> writes addresses 0..15, 0..5 (22 writes); trig_addr=10, start_addr=6; done one cycle after the write to address 5.
- F=4, all kinds NONE, arm -> first mem_we 5 cycles after arm; sample 4 triggers, trig_addr=4, start_addr=0; done after 16 writes spaced 4 cycles apart.
- ch3 FALLING, ch3 toggles 1->0 during PRETRIG only, then steady -> no trigger. busy stays 1 and wr_ptr wraps past 15 -> 0.
- abort in POSTTRIG after 3 post writes, same cycle as arm -> IDLE next cycle; mem_we=0, busy=0, done=0; arm ignored.
- Change prescaling_factor 1->8 mid-acquisition -> write spacing stays 1 cycle until re-arm. Re-arm from DONE -> spacing 8, done cleared.
- rst asserted in WAIT_TRIG -> next cycle all outputs 0 and state IDLE; arm afterwards starts writing at address 0.
